// File: rtl/cla_word_sequencer_pkg.sv
// Shared definitions for the nibble-serial wide adder: FSM encoding, nibble
// width and the index-counter width helper.
package cla_word_sequencer_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-nibble word still needs a 1-bit index register.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cla_word_sequencer_cla.sv
// 4-bit carry-lookahead adder: every carry is a flat sum of generate/propagate
// products so no carry ripples through the sum bits.
module carry_lookahead_adder
  import cla_word_sequencer_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] s,
  output logic           cout
);

  logic [NIB-1:0] g;
  logic [NIB-1:0] p;
  logic [NIB:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  genvar gi;
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_sum
      assign s[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  assign cout = c[NIB];

endmodule

// File: rtl/cla_word_sequencer.sv
// Wide adder that streams WORDS nibbles LSB-first through one shared 4-bit CLA,
// carrying between nibbles in a register; valid/ready on both sides.
module cla_word_sequencer
  import cla_word_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NIB*WORDS-1:0] in_a,
  input  logic [NIB*WORDS-1:0] in_b,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NIB*WORDS-1:0] out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int W     = NIB * WORDS;
  localparam int IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [WORDS-1:0] nib_hit;
  logic [NIB-1:0]   cla_a;
  logic [NIB-1:0]   cla_b;
  logic [NIB-1:0]   cla_s;
  logic             cla_cout;

  // One-hot decode of the nibble index; drives both the operand mux and the
  // sum-register write enables.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_hit
      assign nib_hit[gi] = (idx_q == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    cla_a = '0;
    cla_b = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (nib_hit[i]) begin
        cla_a = cla_a | a_q[i*NIB +: NIB];
        cla_b = cla_b | b_q[i*NIB +: NIB];
      end
    end
  end

  carry_lookahead_adder u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_q),
    .s    (cla_s),
    .cout (cla_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        busy    = 1'b1;
        carry_d = cla_cout;
        for (int i = 0; i < WORDS; i++) begin
          if (nib_hit[i]) begin
            sum_d[i*NIB +: NIB] = cla_s;
          end
        end
        // Index returns to 0 on the last nibble so it never exceeds WORDS-1.
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = carry_q;
  // Overflow: like-signed operands producing a result of the other sign.
  assign out_ovf  = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed bench for the nibble-serial adder: a 4-nibble and a 1-nibble
// instance share clock and reset.
module tb_cla_word_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        in_valid4, in_ready4, in_cin4, out_valid4, out_ready4;
  logic        out_cout4, out_ovf4, busy4;
  logic [15:0] in_a4, in_b4, out_sum4;

  logic        in_valid1, in_ready1, in_cin1, out_valid1, out_ready1;
  logic        out_cout1, out_ovf1, busy1;
  logic [3:0]  in_a1, in_b1, out_sum1;

  cla_word_sequencer #(.WORDS(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_a      (in_a4),
    .in_b      (in_b4),
    .in_cin    (in_cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_sum   (out_sum4),
    .out_cout  (out_cout4),
    .out_ovf   (out_ovf4),
    .busy      (busy4)
  );

  cla_word_sequencer #(.WORDS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_a      (in_a1),
    .in_b      (in_b1),
    .in_cin    (in_cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_sum   (out_sum1),
    .out_cout  (out_cout1),
    .out_ovf   (out_ovf1),
    .busy      (busy1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: got in_ready=%b out_valid=%b busy=%b want 1 0 0",
               in_ready4, out_valid4, busy4);
    end
    checks++;
    if (out_sum4 !== 16'h0000 || out_cout4 !== 1'b0 || out_ovf4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b want 0000 0 0",
               out_sum4, out_cout4, out_ovf4);
    end
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_w1: got in_ready=%b out_valid=%b want 1 0", in_ready1, out_valid1);
    end
    $display("reset: in_ready=%b out_valid=%b busy=%b sum=%h", in_ready4, out_valid4, busy4, out_sum4);
  endtask

  task automatic test_add(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
    int lat;
    in_a4 = a; in_b4 = b; in_cin4 = cin; in_valid4 = 1'b1; out_ready4 = 1'b0;
    checks++;
    if (in_ready4 !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready: got in_ready=%b want 1", name, in_ready4);
    end
    tick();
    in_valid4 = 1'b0;
    lat = 1;
    while (out_valid4 !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 5) begin
      failures++;
      $display("FAIL %s_latency: got %0d want 5", name, lat);
    end
    checks++;
    if (out_sum4 !== exp_sum || out_cout4 !== exp_cout || out_ovf4 !== exp_ovf) begin
      failures++;
      $display("FAIL %s_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
               name, out_sum4, out_cout4, out_ovf4, exp_sum, exp_cout, exp_ovf);
    end
    $display("add %s: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b lat=%0d",
             name, a, b, cin, out_sum4, out_cout4, out_ovf4, lat);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      failures++;
      $display("FAIL %s_handoff: got out_valid=%b in_ready=%b want 0 1", name, out_valid4, in_ready4);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [15:0] seen_sum;
    seen_sum = 16'hxxxx;
    in_a4 = 16'h0001; in_b4 = 16'h0002; in_cin4 = 1'b0;
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    tick();
    n = 0;
    while (in_ready4 !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (out_valid4 === 1'b1) seen_sum = out_sum4;
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL b2b_interval: got in_ready after %0d edges want 5", n);
    end
    checks++;
    if (seen_sum !== 16'h0003) begin
      failures++;
      $display("FAIL b2b_first_sum: got %h want 0003", seen_sum);
    end
    in_a4 = 16'h0010; in_b4 = 16'h0020;
    tick();
    in_valid4 = 1'b0;
    n = 1;
    while (out_valid4 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 5 || out_sum4 !== 16'h0030) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d sum=%h want 5 0030", n, out_sum4);
    end
    $display("b2b: second sum=%h lat=%0d", out_sum4, n);
    tick();
    out_ready4 = 1'b0;
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got in_ready=%b out_valid=%b want 1 0", in_ready4, out_valid4);
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [15:0] k16;
    in_a4 = 16'h1111; in_b4 = 16'h2222; in_cin4 = 1'b0;
    in_valid4 = 1'b1; out_ready4 = 1'b0;
    tick();
    in_valid4 = 1'b0;
    n = 1;
    while (out_valid4 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid4 !== 1'b1) begin
      failures++;
      $display("FAIL bp_done: got out_valid=%b want 1", out_valid4);
    end
    for (int k = 0; k < 10; k++) begin
      k16 = 16'(k);
      in_valid4 = (k % 2 == 0);
      in_a4 = 16'hA5A5 ^ k16;
      in_b4 = 16'h0F0F + k16;
      tick();
      checks++;
      if (out_valid4 !== 1'b1 || in_ready4 !== 1'b0 || out_sum4 !== 16'h3333 ||
          out_cout4 !== 1'b0 || out_ovf4 !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got valid=%b ready=%b sum=%h cout=%b ovf=%b want 1 0 3333 0 0",
                 k, out_valid4, in_ready4, out_sum4, out_cout4, out_ovf4);
      end
    end
    $display("backpressure: held sum=%h for 10 cycles", out_sum4);
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    checks++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || out_sum4 !== 16'h3333) begin
      failures++;
      $display("FAIL bp_release: got valid=%b ready=%b sum=%h want 0 1 3333",
               out_valid4, in_ready4, out_sum4);
    end
  endtask

  task automatic test_reset_mid_run;
    in_a4 = 16'hFFFF; in_b4 = 16'h0001; in_cin4 = 1'b0;
    in_valid4 = 1'b1; out_ready4 = 1'b0;
    tick();
    in_valid4 = 1'b0;
    tick();
    tick();
    checks++;
    if (busy4 !== 1'b1 || out_valid4 !== 1'b0) begin
      failures++;
      $display("FAIL midrun_busy: got busy=%b out_valid=%b want 1 0", busy4, out_valid4);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0 ||
        out_sum4 !== 16'h0000 || out_cout4 !== 1'b0 || out_ovf4 !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset: got ready=%b valid=%b busy=%b sum=%h cout=%b ovf=%b want 1 0 0 0000 0 0",
               in_ready4, out_valid4, busy4, out_sum4, out_cout4, out_ovf4);
    end
    $display("reset mid-run: ready=%b sum=%h cout=%b", in_ready4, out_sum4, out_cout4);
    test_add("after_reset", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
  endtask

  task automatic test_words1;
    logic [3:0] va [2];
    logic [3:0] vb [2];
    logic       vc [2];
    logic [3:0] es [2];
    logic       ec [2];
    logic       eo [2];
    int lat;
    va[0] = 4'hA; vb[0] = 4'h7; vc[0] = 1'b1; es[0] = 4'h2; ec[0] = 1'b1; eo[0] = 1'b0;
    va[1] = 4'h7; vb[1] = 4'h1; vc[1] = 1'b0; es[1] = 4'h8; ec[1] = 1'b0; eo[1] = 1'b1;
    for (int v = 0; v < 2; v++) begin
      in_a1 = va[v]; in_b1 = vb[v]; in_cin1 = vc[v];
      in_valid1 = 1'b1; out_ready1 = 1'b0;
      tick();
      in_valid1 = 1'b0;
      lat = 1;
      while (out_valid1 !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      checks++;
      if (lat != 2 || out_sum1 !== es[v] || out_cout1 !== ec[v] || out_ovf1 !== eo[v]) begin
        failures++;
        $display("FAIL w1_vec%0d: got lat=%0d sum=%h cout=%b ovf=%b want lat=2 sum=%h cout=%b ovf=%b",
                 v, lat, out_sum1, out_cout1, out_ovf1, es[v], ec[v], eo[v]);
      end
      $display("w1 add: a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b lat=%0d",
               va[v], vb[v], vc[v], out_sum1, out_cout1, out_ovf1, lat);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; in_cin4 = 1'b0; out_ready4 = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_cin1 = 1'b0; out_ready1 = 1'b0;
    test_reset();
    test_add("mixed_sign", 16'h0003, 16'hFFFC, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    test_add("full_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_add("pos_ovf", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    test_add("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    test_add("cin_ripple", 16'h9ABC, 16'h6543, 1'b1, 16'h0000, 1'b1, 1'b0);
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_words1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
